// File: rtl/pc_predict_unit.sv
// Registered PC prediction unit for the pipelined Y86 core: selects the fetch PC,
// predicts jXX/call as taken and ret through a circular return-address stack.
module pc_predict_unit #(
    parameter int unsigned            ADDR_W    = 64,
    parameter int unsigned            RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0]      RESET_PC  = '0,
    localparam int unsigned           PTR_W     = $clog2(RAS_DEPTH),
    localparam int unsigned           CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [3:0]        f_icode,
    input  logic [ADDR_W-1:0] f_valC,
    input  logic [ADDR_W-1:0] f_valP,
    input  logic              m_mispredict,
    input  logic [ADDR_W-1:0] m_valA,
    input  logic              w_ret_redir,
    input  logic [ADDR_W-1:0] w_valM,
    output logic [ADDR_W-1:0] f_pc,
    output logic [ADDR_W-1:0] pred_pc,
    output logic              ret_predicted,
    output logic [CNT_W-1:0]  ras_count,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    localparam logic [3:0]       IC_HALT = 4'h0;
    localparam logic [3:0]       IC_JXX  = 4'h7;
    localparam logic [3:0]       IC_CALL = 4'h8;
    localparam logic [3:0]       IC_RET  = 4'h9;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr_r;

    logic              redirect_s;
    logic [PTR_W-1:0]  base_ptr_s;
    logic [CNT_W-1:0]  base_cnt_s;
    logic [ADDR_W-1:0] ras_top_s;
    logic [ADDR_W-1:0] next_pred_s;
    logic [PTR_W-1:0]  next_ptr_s;
    logic [CNT_W-1:0]  next_cnt_s;
    logic              push_s;
    logic              set_ovf_s;
    logic              set_unf_s;

    // Fetch PC select; the older W-stage redirect outranks the M-stage one.
    always_comb begin
        redirect_s = w_ret_redir | m_mispredict;
        if (w_ret_redir) begin
            f_pc = w_valM;
        end else if (m_mispredict) begin
            f_pc = m_valA;
        end else begin
            f_pc = pred_pc;
        end
    end

    // A redirect flushes the stack before this cycle's op, so ops see an empty RAS.
    always_comb begin
        base_ptr_s    = redirect_s ? {PTR_W{1'b0}} : ras_ptr_r;
        base_cnt_s    = redirect_s ? {CNT_W{1'b0}} : ras_count;
        ras_top_s     = ras_mem_r[base_ptr_s - PTR_W'(1)];
        ret_predicted = (f_icode == IC_RET) && (base_cnt_s != {CNT_W{1'b0}});
    end

    // Next prediction and next stack state from the fetched icode.
    always_comb begin
        next_pred_s = f_valP;
        next_ptr_s  = base_ptr_s;
        next_cnt_s  = base_cnt_s;
        push_s      = 1'b0;
        set_ovf_s   = 1'b0;
        set_unf_s   = 1'b0;
        case (f_icode)
            IC_HALT: begin
                next_pred_s = f_pc;
            end
            IC_JXX: begin
                next_pred_s = f_valC;
            end
            IC_CALL: begin
                next_pred_s = f_valC;
                push_s      = 1'b1;
                next_ptr_s  = base_ptr_s + PTR_W'(1);
                if (base_cnt_s == CNT_FULL) begin
                    set_ovf_s = 1'b1;
                end else begin
                    next_cnt_s = base_cnt_s + CNT_W'(1);
                end
            end
            IC_RET: begin
                if (ret_predicted) begin
                    next_pred_s = ras_top_s;
                    next_ptr_s  = base_ptr_s - PTR_W'(1);
                    next_cnt_s  = base_cnt_s - CNT_W'(1);
                end else begin
                    set_unf_s = 1'b1;
                end
            end
            default: begin
                next_pred_s = f_valP;
            end
        endcase
    end

    // Prediction register, stack pointer/count and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_pc       <= RESET_PC;
            ras_ptr_r     <= {PTR_W{1'b0}};
            ras_count     <= {CNT_W{1'b0}};
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (!stall) begin
            pred_pc       <= next_pred_s;
            ras_ptr_r     <= next_ptr_s;
            ras_count     <= next_cnt_s;
            ras_overflow  <= ras_overflow | set_ovf_s;
            ras_underflow <= ras_underflow | set_unf_s;
        end
    end

    // Stack storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (!stall && push_s) begin
            ras_mem_r[base_ptr_s] <= f_valP;
        end
    end

endmodule
